// File: rtl/pwm_pkg.sv
// Shared definitions for the dual-channel BCD PWM motor driver.
// Optional feature macro: PWM_SOFTSTART_EN (ramped shadow loading).
package pwm_pkg;

    localparam logic [1:0]  DIR_FWD        = 2'b10;
    localparam logic [1:0]  DIR_REV        = 2'b01;
    localparam logic [1:0]  DIR_STOP       = 2'b00;
    localparam logic [11:0] BCD_MAX        = 12'h999;
    localparam logic [11:0] SOFTSTART_STEP = 12'h050;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDead
    } ch_state_e;

    // True when every digit of a 3-digit BCD value is 0..9.
    function automatic logic bcd_valid(input logic [11:0] x);
        return (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x[11:8] <= 4'd9);
    endfunction

    // Increment a 3-digit BCD value, wrapping 999 -> 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] x);
        logic [11:0] r;
        r = x;
        if (x == BCD_MAX) begin
            r = '0;
        end else if (x[3:0] != 4'd9) begin
            r[3:0] = x[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (x[7:4] != 4'd9) begin
                r[7:4] = x[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = x[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [9:0] bcd_to_bin(input logic [11:0] x);
        return 10'(x[11:8]) * 10'd100 + 10'(x[7:4]) * 10'd10 + 10'(x[3:0]);
    endfunction

    function automatic logic [11:0] bin_to_bcd(input logic [9:0] b);
        return {4'(b / 10'd100), 4'((b / 10'd10) % 10'd10), 4'(b % 10'd10)};
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One bridge channel: input registers, duty shadow, direction FSM with dead time,
// and the PWM compare. PWM_SOFTSTART_EN ramps the shadow toward the target.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] count,
    input  logic        wrap,
    input  logic [11:0] duty,
    input  logic [1:0]  dir_req,
    output logic        pwm,
    output logic [1:0]  in_bridge,
    output logic        fault
);

    logic [11:0] duty_q;
    logic [1:0]  req_q;
    logic [11:0] shadow_q;
    logic [11:0] shadow_d;
    logic        fault_q;
    ch_state_e   state_q;
    logic [1:0]  dir_q;
    logic [7:0]  dead_q;
    logic        pwm_q;
    logic        req_valid;
    logic        cmp;

    assign req_valid = (req_q == DIR_FWD) || (req_q == DIR_REV);
    // Valid BCD operands compare correctly as plain binary.
    assign cmp       = (count < shadow_q);

    // Register the raw inputs once before any use.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= 12'h000;
            req_q  <= DIR_STOP;
        end else begin
            duty_q <= duty;
            req_q  <= dir_req;
        end
    end

`ifdef PWM_SOFTSTART_EN
    localparam logic [10:0] STEP_BIN = 11'(bcd_to_bin(SOFTSTART_STEP));
    logic [10:0] ss_s;
    logic [10:0] ss_t;
    logic [10:0] ss_n;

    // Move at most one step toward the target, landing exactly on it.
    always_comb begin
        ss_s = {1'b0, bcd_to_bin(shadow_q)};
        ss_t = {1'b0, bcd_to_bin(duty_q)};
        ss_n = ss_t;
        if (ss_t > ss_s + STEP_BIN) begin
            ss_n = ss_s + STEP_BIN;
        end else if (ss_s > ss_t + STEP_BIN) begin
            ss_n = ss_s - STEP_BIN;
        end
        shadow_d = bin_to_bcd(ss_n[9:0]);
    end
`else
    assign shadow_d = duty_q;
`endif

    // Shadow duty updates only at the period wrap; a bad BCD target latches fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 12'h000;
            fault_q  <= 1'b0;
        end else if (wrap) begin
            if (bcd_valid(duty_q)) begin
                shadow_q <= shadow_d;
            end else begin
                fault_q <= 1'b1;
            end
        end
    end

    // Direction FSM; outputs are registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DIR_STOP;
            dead_q  <= 8'd0;
            pwm_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_q <= StRun;
                        dir_q   <= req_q;
                        pwm_q   <= cmp;
                    end else begin
                        dir_q <= DIR_STOP;
                        pwm_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (!req_valid) begin
                        state_q <= StIdle;
                        dir_q   <= DIR_STOP;
                        pwm_q   <= 1'b0;
                    end else if (req_q != dir_q) begin
                        state_q <= StDead;
                        dead_q  <= 8'd0;
                        dir_q   <= DIR_STOP;
                        pwm_q   <= 1'b0;
                    end else begin
                        pwm_q <= cmp;
                    end
                end
                StDead: begin
                    if (!req_valid) begin
                        state_q <= StIdle;
                        dir_q   <= DIR_STOP;
                        pwm_q   <= 1'b0;
                    end else if (dead_q == 8'(DEAD_CYCLES - 1)) begin
                        // Resume with whichever valid direction is requested now.
                        state_q <= StRun;
                        dir_q   <= req_q;
                        pwm_q   <= cmp;
                    end else begin
                        dead_q <= dead_q + 8'd1;
                        dir_q  <= DIR_STOP;
                        pwm_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    dir_q   <= DIR_STOP;
                    pwm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pwm       = pwm_q;
    assign in_bridge = dir_q;
    assign fault     = fault_q;

endmodule

// File: rtl/pwm_driver_motor.sv
// Dual H-bridge PWM driver: shared prescaled 3-digit BCD counter and two
// independent channels. Optional feature macro: PWM_SOFTSTART_EN.
module pwm_driver_motor
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    output logic        pwm_A,
    output logic        pwm_B,
    output logic [1:0]  in_A,
    output logic [1:0]  in_B,
    output logic        period_tick,
    output logic        fault
);

    logic [15:0] pre_q;
    logic [11:0] cnt_q;
    logic        tick_q;
    logic        step;
    logic        wrap;
    logic        fault_a;
    logic        fault_b;

    assign step = (pre_q == 16'(PRESCALE - 1));
    assign wrap = step && (cnt_q == BCD_MAX);

    // Prescaler and BCD period counter; tick marks the first clock of a new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= 16'd0;
            cnt_q  <= 12'h000;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= step ? 16'd0 : pre_q + 16'd1;
            tick_q <= wrap;
            if (step) begin
                cnt_q <= bcd_inc(cnt_q);
            end
        end
    end

    pwm_channel #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch_a (
        .clk      (clk),
        .rst      (rst),
        .count    (cnt_q),
        .wrap     (wrap),
        .duty     (factor_dc_driverA),
        .dir_req  (directie_driverA),
        .pwm      (pwm_A),
        .in_bridge(in_A),
        .fault    (fault_a)
    );

    pwm_channel #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch_b (
        .clk      (clk),
        .rst      (rst),
        .count    (cnt_q),
        .wrap     (wrap),
        .duty     (factor_dc_driverB),
        .dir_req  (directie_driverB),
        .pwm      (pwm_B),
        .in_bridge(in_B),
        .fault    (fault_b)
    );

    assign period_tick = tick_q;
    assign fault       = fault_a | fault_b;

endmodule

// File: tb/tb_pwm_driver_motor.sv
// Directed bench for pwm_driver_motor at PRESCALE=1, DEAD_CYCLES=4.
module tb_pwm_driver_motor;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] factor_dc_driverA;
    logic [11:0] factor_dc_driverB;
    logic [1:0]  directie_driverA;
    logic [1:0]  directie_driverB;
    logic        pwm_A;
    logic        pwm_B;
    logic [1:0]  in_A;
    logic [1:0]  in_B;
    logic        period_tick;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_driver_motor #(
        .PRESCALE   (1),
        .DEAD_CYCLES(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .factor_dc_driverA(factor_dc_driverA),
        .factor_dc_driverB(factor_dc_driverB),
        .directie_driverA (directie_driverA),
        .directie_driverB (directie_driverB),
        .pwm_A            (pwm_A),
        .pwm_B            (pwm_B),
        .in_A             (in_A),
        .in_B             (in_B),
        .period_tick      (period_tick),
        .fault            (fault)
    );

    // Bounded wait for the next period_tick; n is the number of clocks taken.
    task automatic wait_tick(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    // Sample one full period starting just after a tick sample.
    task automatic measure(output int ha, output int hb, output int tpos);
        ha   = 0;
        hb   = 0;
        tpos = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (pwm_A) ha++;
            if (pwm_B) hb++;
            if (period_tick && tpos == 0) tpos = i;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        rst = 1'b1;
        factor_dc_driverA = 12'h000;
        factor_dc_driverB = 12'h000;
        directie_driverA  = 2'b00;
        directie_driverB  = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (pwm_A !== 1'b0) begin errors++; $display("FAIL reset_pwm_A got %b want 0", pwm_A); end
        checks++; if (pwm_B !== 1'b0) begin errors++; $display("FAIL reset_pwm_B got %b want 0", pwm_B); end
        checks++; if (in_A !== 2'b00) begin errors++; $display("FAIL reset_in_A got %b want 00", in_A); end
        checks++; if (in_B !== 2'b00) begin errors++; $display("FAIL reset_in_B got %b want 00", in_B); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", period_tick); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        rst = 1'b0;
        wait_tick(ok, n);
        checks++; if (!ok || n != 1000) begin errors++; $display("FAIL first_tick got %0d want 1000", n); end
    endtask

    task automatic test_full_duty();
        bit ok;
        int n, ha, hb, tpos;
        factor_dc_driverA = 12'h999;
        directie_driverA  = 2'b10;
        factor_dc_driverB = 12'h250;
        directie_driverB  = 2'b01;
        wait_tick(ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL full_tick_timeout got %0d want 1000", n); end
        measure(ha, hb, tpos);
        checks++; if (ha != 999) begin errors++; $display("FAIL full_high_A got %0d want 999", ha); end
        checks++; if (hb != 250) begin errors++; $display("FAIL chanB_high got %0d want 250", hb); end
        checks++; if (tpos != 1000) begin errors++; $display("FAIL tick_period got %0d want 1000", tpos); end
        checks++; if (in_A !== 2'b10) begin errors++; $display("FAIL full_in_A got %b want 10", in_A); end
        checks++; if (in_B !== 2'b01) begin errors++; $display("FAIL chanB_in got %b want 01", in_B); end
    endtask

    // Entered on a tick sample with shadow A = 999.
    task automatic test_duty_change();
        bit ok;
        int n, ha, hb, tpos;
        factor_dc_driverA = 12'h750;
        wait_tick(ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL chg_tick_timeout got %0d want 1000", n); end
        ha = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (pwm_A) ha++;
            if (i == 300) factor_dc_driverA = 12'h500;
        end
        checks++; if (ha != 750) begin errors++; $display("FAIL chg_cur_period got %0d want 750", ha); end
        measure(ha, hb, tpos);
        checks++; if (ha != 500) begin errors++; $display("FAIL chg_next_period got %0d want 500", ha); end
    endtask

    // Entered on a tick sample with shadow A = 500.
    task automatic test_fault();
        bit ok;
        int n, ha, hb, tpos;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_pre got %b want 0", fault); end
        factor_dc_driverA = 12'h9A0;
        wait_tick(ok, n);
        checks++; if (!ok || fault !== 1'b1) begin errors++; $display("FAIL fault_at_wrap got %b want 1", fault); end
        measure(ha, hb, tpos);
        checks++; if (ha != 500) begin errors++; $display("FAIL fault_keep_shadow got %0d want 500", ha); end
        factor_dc_driverA = 12'h300;
        measure(ha, hb, tpos);
        measure(ha, hb, tpos);
        checks++; if (ha != 300) begin errors++; $display("FAIL fault_recover got %0d want 300", ha); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", fault); end
    endtask

    task automatic test_dead_time();
        int n, bad;
        bit left;
        directie_driverA = 2'b01;
        left = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_A !== 2'b10) begin left = 1'b1; break; end
        end
        n   = 0;
        bad = 0;
        while (left && in_A === 2'b00 && n < 20) begin
            if (pwm_A !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 4) begin errors++; $display("FAIL dead_len got %0d want 4", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL dead_pwm got %0d want 0", bad); end
        checks++; if (in_A !== 2'b01) begin errors++; $display("FAIL dead_exit_dir got %b want 01", in_A); end
        directie_driverA = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (in_A !== 2'b00 || pwm_A !== 1'b0) begin
            errors++; $display("FAIL stop_to_idle got %b/%b want 00/0", in_A, pwm_A);
        end
    endtask

    task automatic test_reset_mid_dead();
        bit ok;
        int n;
        directie_driverA = 2'b01;
        wait_tick(ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL mid_tick_timeout got %0d want tick", n); end
        repeat (597) @(negedge clk);
        directie_driverA = 2'b10;
        repeat (2) @(negedge clk);
        checks++; if (in_A !== 2'b00) begin errors++; $display("FAIL mid_in_dead got %b want 00", in_A); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (pwm_A !== 1'b0 || pwm_B !== 1'b0) begin
            errors++; $display("FAIL mid_rst_pwm got %b%b want 00", pwm_A, pwm_B);
        end
        checks++; if (in_A !== 2'b00 || in_B !== 2'b00) begin
            errors++; $display("FAIL mid_rst_in got %b/%b want 00/00", in_A, in_B);
        end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %b want 0", period_tick); end
`ifndef PWM_SOFTSTART_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_rst_fault got %b want 0", fault); end
`endif
        wait_tick(ok, n);
        checks++; if (!ok || n != 1000) begin errors++; $display("FAIL mid_restart got %0d want 1000", n); end
    endtask

`ifdef PWM_SOFTSTART_EN
    // Entered on a tick sample with shadow A = 0.
    task automatic test_softstart();
        int ha, hb, tpos, want, bad;
        factor_dc_driverA = 12'h999;
        directie_driverA  = 2'b10;
        measure(ha, hb, tpos);
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            measure(ha, hb, tpos);
            want = (k * 50 > 999) ? 999 : k * 50;
            if (ha != want) begin
                bad++;
                $display("FAIL softstart_step%0d got %0d want %0d", k, ha, want);
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL softstart_ramp got %0d want 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PWM_SOFTSTART_EN
        test_softstart();
`else
        test_full_duty();
        test_duty_change();
        test_fault();
`endif
        test_dead_time();
        test_reset_mid_dead();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
